// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: converts one "read N words from address A" request into
// a run of read commands for the SDRAM controller's command FIFO and gathers the
// matching readouts into a ready/valid stream. The controller's readout port
// cannot be stalled, so a command is only issued once a buffer slot is reserved
// for its response (outstanding + count never exceeds BUF_DEPTH).
module sdram_stream_reader #(
  parameter int BUF_DEPTH = 16,
  parameter int BUF_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] startAddr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        stray,
  output logic        cmdWrite,
  input  logic        cmdFull,
  output logic        cmdIsWrite,
  output logic [24:0] cmdAddress,
  output logic [1:0]  cmdWriteMask,
  output logic [15:0] cmdWriteData,
  input  logic        readValid,
  input  logic [24:0] raddr,
  input  logic [15:0] rdata,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] outData,
  output logic        outLast
);

  localparam int DATA_W = 16;
  localparam logic [BUF_AW+1:0] DEPTH_C = (BUF_AW+2)'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [24:0]       issue_addr_q, issue_addr_d;
  logic [24:0]       exp_addr_q, exp_addr_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       issued_q, issued_d;
  logic [15:0]       received_q, received_d;
  logic [15:0]       popped_q, popped_d;
  logic [BUF_AW:0]   outstanding_q, outstanding_d;
  logic [BUF_AW:0]   count_q, count_d;
  logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic              done_q, done_d;
  logic              stray_q, stray_d;

  // Each entry holds {data, last}; storage is data-path only and never reset.
  logic [DATA_W:0]   mem_q [BUF_DEPTH];
  logic [DATA_W:0]   head;

  logic              active;
  logic              issue;
  logic              accept;
  logic              pop;
  logic [BUF_AW+1:0] credits_used;

  assign active       = (state_q != S_IDLE);
  assign credits_used = {1'b0, outstanding_q} + {1'b0, count_q};
  // A command needs a free slot for its eventual response, counting both
  // in-flight reads and words already buffered.
  assign issue  = (state_q == S_ISSUE) && !cmdFull && (credits_used < DEPTH_C)
                  && (issued_q < len_q);
  // Only the next expected address is taken; anything else is a stray.
  assign accept = active && readValid && (raddr == exp_addr_q) && (received_q < len_q);
  assign pop    = (count_q != '0) && outReady;
  assign head   = mem_q[rd_ptr_q];

  // Next-state logic: counters, addresses and FSM transitions.
  always_comb begin
    state_d       = state_q;
    issue_addr_d  = issue_addr_q;
    exp_addr_d    = exp_addr_q;
    len_d         = len_q;
    issued_d      = issued_q;
    received_d    = received_q;
    popped_d      = popped_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    done_d        = 1'b0;
    stray_d       = active && readValid && !accept;

    if (issue) begin
      issue_addr_d = issue_addr_q + 25'd1;
      issued_d     = issued_q + 16'd1;
    end
    if (accept) begin
      exp_addr_d = exp_addr_q + 25'd1;
      received_d = received_q + 16'd1;
    end
    if (pop) begin
      popped_d = popped_q + 16'd1;
    end

    case ({issue, accept})
      2'b10:   outstanding_d = outstanding_q + (BUF_AW+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (BUF_AW+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case ({accept, pop})
      2'b10:   count_d = count_q + (BUF_AW+1)'(1);
      2'b01:   count_d = count_q - (BUF_AW+1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != 16'd0) begin
            issue_addr_d = startAddr;
            exp_addr_d   = startAddr;
            len_d        = length;
            issued_d     = 16'd0;
            received_d   = 16'd0;
            popped_d     = 16'd0;
            state_d      = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issued_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the edge of the final pop so done and !busy appear together.
        if (popped_d == len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      issue_addr_q  <= '0;
      exp_addr_q    <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      popped_q      <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_addr_q  <= issue_addr_d;
      exp_addr_q    <= exp_addr_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      popped_q      <= popped_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      if (accept) wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + BUF_AW'(1);
      done_q        <= done_d;
      stray_q       <= stray_d;
    end
  end

  // Buffer write: store accepted readouts tagged with the end-of-transfer flag.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {rdata, (received_q == len_q - 16'd1)};
  end

  assign busy         = active;
  assign done         = done_q;
  assign stray        = stray_q;
  assign cmdWrite     = issue;
  assign cmdIsWrite   = 1'b0;
  assign cmdAddress   = issue_addr_q;
  assign cmdWriteMask = 2'b11;
  assign cmdWriteData = 16'd0;
  assign outValid     = (count_q != '0);
  // Head is gated so the stream outputs read as zero while the buffer is empty.
  assign outData      = outValid ? head[DATA_W:1] : '0;
  assign outLast      = outValid & head[0];

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Testbench for sdram_stream_reader: a simple SDRAM controller model answers
// read commands in order after a random latency; a queue of expected words
// built from each request is compared against the output stream.
module tb_sdram_stream_reader;

  localparam int BUF_DEPTH = 16;
  localparam int BUF_AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [24:0] startAddr;
  logic [15:0] length;
  logic        busy, done, stray;
  logic        cmdWrite, cmdFull, cmdIsWrite;
  logic [24:0] cmdAddress;
  logic [1:0]  cmdWriteMask;
  logic [15:0] cmdWriteData;
  logic        readValid;
  logic [24:0] raddr;
  logic [15:0] rdata;
  logic        outValid, outReady, outLast;
  logic [15:0] outData;

  always #5 clk = ~clk;

  sdram_stream_reader #(.BUF_DEPTH(BUF_DEPTH), .BUF_AW(BUF_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .length(length),
    .busy(busy), .done(done), .stray(stray),
    .cmdWrite(cmdWrite), .cmdFull(cmdFull), .cmdIsWrite(cmdIsWrite),
    .cmdAddress(cmdAddress), .cmdWriteMask(cmdWriteMask), .cmdWriteData(cmdWriteData),
    .readValid(readValid), .raddr(raddr), .rdata(rdata),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [16:0] exp_q[$];
  logic [24:0] ctl_addr[$];
  int          ctl_due[$];
  logic [24:0] exp_issue_addr = '0;
  int cyc = 0, cmd_cnt = 0, pop_cnt = 0, stray_seen = 0, stray_inj = 0;
  int ready_pct = 100, full_pct = 0;
  bit force_full = 0, inject_stray = 0, exp_done = 0, done_seen = 0;
  bit go = 0;
  logic [24:0] go_addr = '0;
  logic [15:0] go_len = '0;

  // Memory contents seen by the controller model: 0x100+i holds 0xA000+i.
  function automatic logic [15:0] data_of(input logic [24:0] a);
    return 16'hA000 + (a[15:0] - 16'h0100);
  endfunction

  task automatic cycle();
    logic [16:0] e;
    @(negedge clk);
    readValid = 1'b0; raddr = '0; rdata = '0;
    if (ctl_addr.size() > 0 && cyc >= ctl_due[0] && $urandom_range(0, 3) != 0) begin
      readValid = 1'b1;
      raddr     = ctl_addr[0];
      rdata     = data_of(ctl_addr[0]);
      void'(ctl_addr.pop_front());
      void'(ctl_due.pop_front());
    end else if (inject_stray && busy) begin
      readValid = 1'b1; raddr = 25'h55; rdata = 16'hDEAD;
      inject_stray = 0; stray_inj++;
    end
    cmdFull   = force_full || ($urandom_range(0, 99) < full_pct);
    outReady  = ($urandom_range(0, 99) < ready_pct);
    start     = go;
    startAddr = go_addr;
    length    = go_len;
    #1;
    chk("done", done, exp_done);
    if (exp_done) begin
      chk("busy_after_done", busy, 0);
      done_seen = 1;
    end
    exp_done = 0;
    if (stray) stray_seen++;
    if (cmdFull) chk("cmd_while_full", cmdWrite, 0);
    if (cmdWrite) begin
      chk("cmd_addr", cmdAddress, exp_issue_addr);
      ctl_addr.push_back(cmdAddress);
      ctl_due.push_back(cyc + 2 + int'($urandom_range(0, 5)));
      exp_issue_addr = exp_issue_addr + 25'd1;
      cmd_cnt++;
    end
    if (outValid && outReady && !rst) begin
      chk("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", outData, e[16:1]);
        chk("out_last", outLast, e[0]);
        if (e[0]) exp_done = 1;
      end
      pop_cnt++;
    end
    chk("credit_bound", (cmd_cnt - pop_cnt) <= BUF_DEPTH, 1);
    if (go && !rst && !busy) begin
      cmd_cnt = 0; pop_cnt = 0;
      if (go_len == 16'd0) exp_done = 1;
      else begin
        exp_issue_addr = go_addr;
        for (int i = 0; i < int'(go_len); i++)
          exp_q.push_back({data_of(go_addr + 25'(i)), i == int'(go_len) - 1});
      end
    end
    go = 0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0; cmd_cnt = 0; pop_cnt = 0; inject_stray = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_stray"},    stray, 0);
    chk({tag, "_cmdwr"},    cmdWrite, 0);
    chk({tag, "_iswr"},     cmdIsWrite, 0);
    chk({tag, "_cmdaddr"},  cmdAddress, 0);
    chk({tag, "_mask"},     cmdWriteMask, 3);
    chk({tag, "_wdata"},    cmdWriteData, 0);
    chk({tag, "_outvalid"}, outValid, 0);
    chk({tag, "_outdata"},  outData, 0);
    chk({tag, "_outlast"},  outLast, 0);
  endtask

  task automatic launch(input logic [24:0] a, input logic [15:0] n);
    go = 1; go_addr = a; go_len = n; done_seen = 0;
    cycle();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done_seen && k < budget) begin
      cycle();
      k++;
    end
    chk({tag, "_finished"}, done_seen, 1);
  endtask

  task automatic finish_xfer(input string tag, input int n);
    chk({tag, "_left"},  exp_q.size(), 0);
    chk({tag, "_cmds"},  cmd_cnt, n);
    chk({tag, "_words"}, pop_cnt, n);
  endtask

  initial begin
    int s0, c0;
    rst = 1'b1; start = 1'b0; startAddr = '0; length = '0; cmdFull = 1'b0;
    readValid = 1'b0; raddr = '0; rdata = '0; outReady = 1'b0;
    do_reset(3);
    #1;
    check_reset_vals("rst0");

    // Basic read
    ready_pct = 100; full_pct = 0;
    launch(25'h100, 16'd8);
    wait_done(300, "basic");
    finish_xfer("basic", 8);
    chk("basic_stray", stray_seen, 0);

    // Backpressure: only BUF_DEPTH commands before anything drains
    ready_pct = 0;
    launch(25'h2000, 16'd64);
    repeat (80) cycle();
    #1;
    chk("bp_cmds", cmd_cnt, 16);
    chk("bp_valid", outValid, 1);
    ready_pct = 100;
    wait_done(800, "bp");
    finish_xfer("bp", 64);

    // cmdFull throttle mid-issue
    ready_pct = 70; full_pct = 10;
    launch(25'h30000, 16'd40);
    for (int k = 0; k < 200 && cmd_cnt < 5; k++) cycle();
    chk("throttle_reach", cmd_cnt >= 5, 1);
    c0 = cmd_cnt;
    force_full = 1;
    repeat (20) cycle();
    chk("throttle_nocmd", cmd_cnt, c0);
    force_full = 0;
    wait_done(800, "throttle");
    finish_xfer("throttle", 40);

    // Address wrap plus an injected stray readout
    ready_pct = 100; full_pct = 0;
    s0 = stray_seen;
    launch(25'h1FFFFFE, 16'd4);
    inject_stray = 1;
    wait_done(300, "wrap");
    repeat (3) cycle();
    finish_xfer("wrap", 4);
    chk("wrap_stray", stray_seen - s0, 1);

    // Reset mid-transfer, late responses dropped in IDLE, then a fresh transfer
    ready_pct = 60;
    launch(25'h40000, 16'd32);
    for (int k = 0; k < 400 && pop_cnt < 5; k++) cycle();
    chk("midrst_reach", pop_cnt >= 5, 1);
    do_reset(1);
    #1;
    check_reset_vals("midrst");
    s0 = stray_seen;
    for (int k = 0; k < 100 && ctl_addr.size() > 0; k++) cycle();
    repeat (3) cycle();
    chk("idle_drained", ctl_addr.size(), 0);
    chk("idle_stray", stray_seen - s0, 0);
    ready_pct = 100;
    launch(25'h50000, 16'd3);
    wait_done(200, "post_rst");
    finish_xfer("post_rst", 3);

    // length 0 is a no-op with a done pulse
    launch(25'h60000, 16'd0);
    wait_done(10, "len0");
    repeat (3) cycle();
    finish_xfer("len0", 0);

    // start while busy is ignored
    launch(25'h70000, 16'd20);
    repeat (3) cycle();
    chk("busy_start_inissue", busy, 1);
    launch(25'h1234, 16'd5);
    wait_done(400, "busy_start");
    finish_xfer("busy_start", 20);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      ready_pct = int'($urandom_range(30, 100));
      full_pct  = int'($urandom_range(0, 40));
      launch(25'($urandom_range(32'h1000, 32'h1FF0000)), 16'($urandom_range(1, 48)));
      if ($urandom_range(0, 1) == 1) inject_stray = 1;
      wait_done(2000, "rand");
      finish_xfer("rand", int'(go_len));
    end
    repeat (5) cycle();
    chk("stray_total", stray_seen, stray_inj);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
